// File: rtl/parking_pkg.sv
// Shared definitions for the parking-garage controller: FSM states, completion codes
// and the slot-type helper used by the slot finder.
package parking_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StUp,
    StAct,
    StDown,
    StDone
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_FULL = 2'd1;
  localparam logic [1:0] ERR_MISS = 2'd2;  // duplicate on park, not found on retrieve
  localparam logic [1:0] ERR_BAD  = 2'd3;

  // Slots at or above the sedan count on each floor are SUV slots.
  function automatic logic slot_is_suv(input int unsigned slot, input int unsigned sedan_slots);
    return slot >= sedan_slots;
  endfunction

endpackage

// File: rtl/parking_slot_finder.sv
// Combinational priority encoder: lowest non-leaking floor first, then lowest free slot
// of the requested vehicle type on that floor.
module parking_slot_finder import parking_pkg::*; #(
  parameter int unsigned FLOORS      = 7,
  parameter int unsigned SEDAN_SLOTS = 4,
  parameter int unsigned SUV_SLOTS   = 4,
  localparam int unsigned SLOTS      = SEDAN_SLOTS + SUV_SLOTS,
  localparam int unsigned FLW        = $clog2(FLOORS + 1),
  localparam int unsigned SLW        = $clog2(SLOTS)
) (
  input  logic [FLOORS*SLOTS-1:0] i_occ,
  input  logic [FLOORS-1:0]       i_leak_mask,
  input  logic                    i_suv,
  output logic                    o_found,
  output logic [FLW-1:0]          o_floor,
  output logic [SLW-1:0]          o_slot
);

  logic           w_found;
  logic [FLW-1:0] w_floor;
  logic [SLW-1:0] w_slot;

  // First match in floor-major order wins.
  always_comb begin
    w_found = 1'b0;
    w_floor = '0;
    w_slot  = '0;
    for (int f = 0; f < FLOORS; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (!w_found && !i_leak_mask[f] && !i_occ[f*SLOTS+s] &&
            (slot_is_suv(s, SEDAN_SLOTS) == i_suv)) begin
          w_found = 1'b1;
          w_floor = FLW'(f + 1);
          w_slot  = SLW'(s);
        end
      end
    end
  end

  assign o_found = w_found;
  assign o_floor = w_floor;
  assign o_slot  = w_slot;

endmodule

// File: rtl/parking_garage_ctrl.sv
// Parking-garage controller: one request at a time, one-floor-per-cycle elevator,
// plate occupancy table and optional time-based fee.
// Optional feature: define PARKING_FEE_EN to add the timestamp counter, per-slot entry
// stamps and the retrieve fee; without it done_fee is tied to zero.
module parking_garage_ctrl import parking_pkg::*; #(
  parameter int unsigned FLOORS      = 7,
  parameter int unsigned SEDAN_SLOTS = 4,
  parameter int unsigned SUV_SLOTS   = 4,
  parameter int unsigned PLATE_W     = 16,
  parameter int unsigned FEE_W       = 8,
  parameter int unsigned TS_W        = 8,
  parameter int unsigned FEE_RATE    = 1,
  localparam int unsigned SLOTS      = SEDAN_SLOTS + SUV_SLOTS,
  localparam int unsigned NSLOT      = FLOORS * SLOTS,
  localparam int unsigned FLW        = $clog2(FLOORS + 1),
  localparam int unsigned SLW        = $clog2(SLOTS),
  localparam int unsigned CW         = $clog2(NSLOT + 1),
  localparam int unsigned IW         = $clog2(NSLOT)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_out,
  input  logic               req_suv,
  input  logic [PLATE_W-1:0] req_plate,
  input  logic [FLOORS-1:0]  leak_mask,
  output logic               done_valid,
  output logic [1:0]         done_err,
  output logic [FLW-1:0]     done_floor,
  output logic [SLW-1:0]     done_slot,
  output logic [FEE_W-1:0]   done_fee,
  output logic [FLW-1:0]     cur_floor,
  output logic [PLATE_W-1:0] moving_plate,
  output logic [NSLOT-1:0]   occ,
  output logic [CW-1:0]      empty_sedan,
  output logic [CW-1:0]      empty_suv,
  output logic               full_sedan,
  output logic               full_suv
);

  state_e             r_state;
  logic [FLW-1:0]     r_cur_floor;
  logic [FLW-1:0]     r_tgt_floor;
  logic [SLW-1:0]     r_tgt_slot;
  logic               r_out;
  logic               r_suv;
  logic [PLATE_W-1:0] r_plate;
  logic [NSLOT-1:0]   r_occ;
  logic [PLATE_W-1:0] r_plates [NSLOT];
  logic               r_done_valid;
  logic [1:0]         r_done_err;
  logic [FLW-1:0]     r_done_floor;
  logic [SLW-1:0]     r_done_slot;
  logic [PLATE_W-1:0] r_moving_plate;

  logic               w_found;
  logic [FLW-1:0]     w_free_floor;
  logic [SLW-1:0]     w_free_slot;
  logic               w_hit;
  logic [FLW-1:0]     w_hit_floor;
  logic [SLW-1:0]     w_hit_slot;
  logic [1:0]         w_err;
  logic [IW-1:0]      w_tgt_idx;

  parking_slot_finder #(
    .FLOORS     (FLOORS),
    .SEDAN_SLOTS(SEDAN_SLOTS),
    .SUV_SLOTS  (SUV_SLOTS)
  ) u_finder (
    .i_occ      (r_occ),
    .i_leak_mask(leak_mask),
    .i_suv      (r_suv),
    .o_found    (w_found),
    .o_floor    (w_free_floor),
    .o_slot     (w_free_slot)
  );

  // Plate CAM over occupied slots; leaking floors are still searched.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_floor = '0;
    w_hit_slot  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!w_hit && r_occ[i] && (r_plates[i] == r_plate)) begin
        w_hit       = 1'b1;
        w_hit_floor = FLW'(i / SLOTS + 1);
        w_hit_slot  = SLW'(i % SLOTS);
      end
    end
  end

  // Request verdict in priority order BAD_PLATE > DUP/NOTFOUND > FULL.
  always_comb begin
    w_err = ERR_OK;
    if (r_plate == '0) begin
      w_err = ERR_BAD;
    end else if (!r_out && w_hit) begin
      w_err = ERR_MISS;
    end else if (r_out && !w_hit) begin
      w_err = ERR_MISS;
    end else if (!r_out && !w_found) begin
      w_err = ERR_FULL;
    end
  end

  // Flat slot index of the latched target (only meaningful from UP onwards).
  always_comb begin
    w_tgt_idx = IW'((32'(r_tgt_floor) - 32'd1) * SLOTS + 32'(r_tgt_slot));
  end

  // Free-slot counts on non-leaking floors, per vehicle type.
  always_comb begin
    int unsigned v_sed;
    int unsigned v_suv;
    v_sed = 0;
    v_suv = 0;
    for (int f = 0; f < FLOORS; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (!leak_mask[f] && !r_occ[f*SLOTS+s]) begin
          if (slot_is_suv(s, SEDAN_SLOTS)) v_suv++;
          else                             v_sed++;
        end
      end
    end
    empty_sedan = CW'(v_sed);
    empty_suv   = CW'(v_suv);
  end

`ifdef PARKING_FEE_EN
  localparam logic [63:0] FEE_MAX = (64'd1 << FEE_W) - 64'd1;

  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_stamp [NSLOT];
  logic [FEE_W-1:0] r_fee;
  logic [FEE_W-1:0] r_done_fee;
  logic [TS_W-1:0]  w_elapsed;
  logic [63:0]      w_prod;
  logic [FEE_W-1:0] w_fee;

  // Elapsed time wraps modulo 2^TS_W; the product saturates at the fee width.
  always_comb begin
    w_elapsed = r_ts - r_stamp[w_tgt_idx];
    w_prod    = 64'(w_elapsed) * 64'(FEE_RATE);
    w_fee     = (w_prod > FEE_MAX) ? '1 : w_prod[FEE_W-1:0];
  end

  // Free-running timestamp, entry stamps at park ACT, fee capture at retrieve ACT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ts       <= '0;
      r_fee      <= '0;
      r_done_fee <= '0;
      for (int i = 0; i < NSLOT; i++) r_stamp[i] <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (r_state == StIdle && req_valid) begin
        r_fee <= '0;
      end
      if (r_state == StAct) begin
        if (r_out) r_fee <= w_fee;
        else       r_stamp[w_tgt_idx] <= r_ts;
      end
      if (r_state == StDown && r_cur_floor == FLW'(1)) begin
        r_done_fee <= r_fee;
      end else begin
        r_done_fee <= '0;
      end
    end
  end

  assign done_fee = r_done_fee;
`else
  assign done_fee = '0;
`endif

  // Request FSM with elevator position, occupancy table and registered completion outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_cur_floor    <= '0;
      r_tgt_floor    <= '0;
      r_tgt_slot     <= '0;
      r_out          <= 1'b0;
      r_suv          <= 1'b0;
      r_plate        <= '0;
      r_occ          <= '0;
      r_done_valid   <= 1'b0;
      r_done_err     <= ERR_OK;
      r_done_floor   <= '0;
      r_done_slot    <= '0;
      r_moving_plate <= '0;
      for (int i = 0; i < NSLOT; i++) r_plates[i] <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_out          <= req_out;
            r_suv          <= req_suv;
            r_plate        <= req_plate;
            r_moving_plate <= req_out ? '0 : req_plate;
            r_state        <= StSearch;
          end
        end
        StSearch: begin
          if (w_err != ERR_OK) begin
            r_done_valid   <= 1'b1;
            r_done_err     <= w_err;
            r_done_floor   <= '0;
            r_done_slot    <= '0;
            r_moving_plate <= '0;
            r_state        <= StDone;
          end else begin
            r_tgt_floor <= r_out ? w_hit_floor : w_free_floor;
            r_tgt_slot  <= r_out ? w_hit_slot : w_free_slot;
            r_state     <= StUp;
          end
        end
        StUp: begin
          r_cur_floor <= r_cur_floor + 1'b1;
          if (r_cur_floor + 1'b1 == r_tgt_floor) r_state <= StAct;
        end
        StAct: begin
          if (r_out) begin
            r_occ[w_tgt_idx]    <= 1'b0;
            r_plates[w_tgt_idx] <= '0;
            r_moving_plate      <= r_plate;
          end else begin
            r_occ[w_tgt_idx]    <= 1'b1;
            r_plates[w_tgt_idx] <= r_plate;
            r_moving_plate      <= '0;
          end
          r_state <= StDown;
        end
        StDown: begin
          r_cur_floor <= r_cur_floor - 1'b1;
          if (r_cur_floor == FLW'(1)) begin
            r_done_valid   <= 1'b1;
            r_done_err     <= ERR_OK;
            r_done_floor   <= r_tgt_floor;
            r_done_slot    <= r_tgt_slot;
            r_moving_plate <= '0;
            r_state        <= StDone;
          end
        end
        StDone: begin
          r_done_valid <= 1'b0;
          r_done_err   <= ERR_OK;
          r_done_floor <= '0;
          r_done_slot  <= '0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready    = (r_state == StIdle);
  assign done_valid   = r_done_valid;
  assign done_err     = r_done_err;
  assign done_floor   = r_done_floor;
  assign done_slot    = r_done_slot;
  assign cur_floor    = r_cur_floor;
  assign moving_plate = r_moving_plate;
  assign occ          = r_occ;
  assign full_sedan   = (empty_sedan == '0);
  assign full_suv     = (empty_suv == '0);

endmodule

// File: tb/tb_parking_garage_ctrl.sv
// Directed bench for parking_garage_ctrl with default parameters.
module tb_parking_garage_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_out;
  logic        req_suv;
  logic [15:0] req_plate;
  logic [6:0]  leak_mask;
  logic        done_valid;
  logic [1:0]  done_err;
  logic [2:0]  done_floor;
  logic [2:0]  done_slot;
  logic [7:0]  done_fee;
  logic [2:0]  cur_floor;
  logic [15:0] moving_plate;
  logic [55:0] occ;
  logic [5:0]  empty_sedan;
  logic [5:0]  empty_suv;
  logic        full_sedan;
  logic        full_suv;

  int checks = 0;
  int errors = 0;

  parking_garage_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_out     (req_out),
    .req_suv     (req_suv),
    .req_plate   (req_plate),
    .leak_mask   (leak_mask),
    .done_valid  (done_valid),
    .done_err    (done_err),
    .done_floor  (done_floor),
    .done_slot   (done_slot),
    .done_fee    (done_fee),
    .cur_floor   (cur_floor),
    .moving_plate(moving_plate),
    .occ         (occ),
    .empty_sedan (empty_sedan),
    .empty_suv   (empty_suv),
    .full_sedan  (full_sedan),
    .full_suv    (full_suv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to its completion pulse.
  // lat = number of edges after the accept edge until done_valid is seen.
  task automatic do_req(input logic out, input logic suv, input logic [15:0] plate,
                        output int lat, output logic [1:0] err, output logic [2:0] fl,
                        output logic [2:0] sl, output logic [7:0] fee,
                        output logic [15:0] mp, output logic jump);
    logic [2:0] prev;
    logic       seen;
    @(negedge clock);
    check_val("ready_before_req", req_ready, 1);
    req_out   = out;
    req_suv   = suv;
    req_plate = plate;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    jump = 1'b0;
    prev = cur_floor;
    mp   = '0;
    err  = '0;
    fl   = '0;
    sl   = '0;
    fee  = '0;
    while (!seen && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if ((cur_floor > prev) ? (cur_floor - prev > 1) : (prev - cur_floor > 1)) jump = 1'b1;
      prev = cur_floor;
      if (lat == 1) mp = moving_plate;
      if (done_valid) begin
        seen = 1'b1;
        err  = done_err;
        fl   = done_floor;
        sl   = done_slot;
        fee  = done_fee;
      end
    end
    check_val("done_seen", seen, 1);
    @(posedge clock);
    #1;
    check_val("done_one_cycle", done_valid, 0);
    check_val("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int          lat;
    logic [1:0]  err;
    logic [2:0]  fl;
    logic [2:0]  sl;
    logic [7:0]  fee;
    logic [15:0] mp;
    logic        jump;
    logic [7:0]  exp_fee;

`ifdef PARKING_FEE_EN
    exp_fee = 8'd20;
`else
    exp_fee = 8'd0;
`endif

    reset     = 1'b0;
    req_valid = 1'b0;
    req_out   = 1'b0;
    req_suv   = 1'b0;
    req_plate = '0;
    leak_mask = '0;
    #12;
    check_val("rst_cur_floor", cur_floor, 0);
    check_val("rst_occ", occ, 0);
    check_val("rst_done_valid", done_valid, 0);
    check_val("rst_moving_plate", moving_plate, 0);
    check_val("rst_empty_sedan", empty_sedan, 28);
    check_val("rst_empty_suv", empty_suv, 28);
    check_val("rst_full_sedan", full_sedan, 0);
    @(negedge clock);
    reset = 1'b1;

    // Sedan park goes to floor 1 slot 0.
    do_req(1'b0, 1'b0, 16'h9423, lat, err, fl, sl, fee, mp, jump);
    check_val("park1_lat", lat, 4);
    check_val("park1_err", err, 0);
    check_val("park1_floor", fl, 1);
    check_val("park1_slot", sl, 0);
    check_val("park1_moving", mp, 16'h9423);
    check_val("park1_empty_sedan", empty_sedan, 27);
    check_val("park1_occ0", occ[0], 1);

    // SUV parked at k, retrieved at k+20.
    do_req(1'b0, 1'b1, 16'h8754, lat, err, fl, sl, fee, mp, jump);
    check_val("suv_park_floor", fl, 1);
    check_val("suv_park_slot", sl, 4);
    check_val("suv_occ4_set", occ[4], 1);
    check_val("suv_empty", empty_suv, 27);
    repeat (14) @(posedge clock);
    do_req(1'b1, 1'b0, 16'h8754, lat, err, fl, sl, fee, mp, jump);
    check_val("ret_lat", lat, 4);
    check_val("ret_err", err, 0);
    check_val("ret_floor", fl, 1);
    check_val("ret_slot", sl, 4);
    check_val("ret_fee", fee, exp_fee);
    check_val("ret_moving_up_empty", mp, 0);
    check_val("ret_occ4_clear", occ[4], 0);

    // Floor 1 leaking: sedan goes to floor 2.
    leak_mask = 7'b0000001;
    do_req(1'b0, 1'b0, 16'h1234, lat, err, fl, sl, fee, mp, jump);
    check_val("leak_lat", lat, 6);
    check_val("leak_floor", fl, 2);
    check_val("leak_slot", sl, 0);
    check_val("leak_no_jump", jump, 0);
    check_val("leak_empty_sedan", empty_sedan, 23);
    leak_mask = 7'b0000000;
    #1;
    check_val("noleak_empty_sedan", empty_sedan, 26);

    // Fill the remaining 26 sedan slots; last lands on floor 7 slot 3.
    for (int i = 0; i < 26; i++) begin
      do_req(1'b0, 1'b0, 16'h2000 + 16'(i), lat, err, fl, sl, fee, mp, jump);
      check_val("fill_err", err, 0);
    end
    check_val("fill_last_lat", lat, 16);
    check_val("fill_last_floor", fl, 7);
    check_val("fill_last_slot", sl, 3);
    check_val("fill_no_jump", jump, 0);
    check_val("full_sedan", full_sedan, 1);
    check_val("full_empty_sedan", empty_sedan, 0);

    do_req(1'b0, 1'b0, 16'h3000, lat, err, fl, sl, fee, mp, jump);
    check_val("full_lat", lat, 1);
    check_val("full_err", err, 1);
    check_val("full_floor", fl, 0);
    do_req(1'b0, 1'b1, 16'h3001, lat, err, fl, sl, fee, mp, jump);
    check_val("suv_when_full_err", err, 0);
    check_val("suv_when_full_floor", fl, 1);
    check_val("suv_when_full_slot", sl, 4);

    // Error codes.
    do_req(1'b1, 1'b0, 16'h1111, lat, err, fl, sl, fee, mp, jump);
    check_val("notfound_err", err, 2);
    check_val("notfound_lat", lat, 1);
    check_val("notfound_fee", fee, 0);
    do_req(1'b0, 1'b1, 16'h9423, lat, err, fl, sl, fee, mp, jump);
    check_val("dup_err", err, 2);
    do_req(1'b0, 1'b1, 16'h0000, lat, err, fl, sl, fee, mp, jump);
    check_val("bad_err", err, 3);
    do_req(1'b1, 1'b0, 16'h0000, lat, err, fl, sl, fee, mp, jump);
    check_val("bad_ret_err", err, 3);

    // Retrieve from a leaking floor is still served.
    leak_mask = 7'b0000001;
    do_req(1'b1, 1'b0, 16'h9423, lat, err, fl, sl, fee, mp, jump);
    check_val("leak_ret_err", err, 0);
    check_val("leak_ret_floor", fl, 1);
    check_val("leak_ret_slot", sl, 0);
    check_val("leak_ret_empty", empty_sedan, 0);
    leak_mask = 7'b0000000;
    #1;
    check_val("after_ret_empty", empty_sedan, 1);

    // Reset while the car is climbing past floor 3 toward floor 4.
    leak_mask = 7'b0000111;
    @(negedge clock);
    req_out   = 1'b0;
    req_suv   = 1'b1;
    req_plate = 16'h5555;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check_val("mid_moving", moving_plate, 16'h5555);
    repeat (4) @(posedge clock);
    #1;
    check_val("mid_floor3", cur_floor, 3);
    check_val("mid_busy", req_ready, 0);
    reset = 1'b0;
    #1;
    check_val("mid_rst_floor", cur_floor, 0);
    check_val("mid_rst_occ", occ, 0);
    check_val("mid_rst_moving", moving_plate, 0);
    leak_mask = 7'b0000000;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_val("post_rst_ready", req_ready, 1);
    check_val("post_rst_done", done_valid, 0);
    check_val("post_rst_empty", empty_sedan, 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
